bt_pipe_out_source: RTL

Buffered pseudorandom/counter data source feeding the block-throttled pipe-out endpoint (okBTPipeOut, address 0xA0) on ti_clk. A generator fills an internal FIFO one word per cycle, gated by a rotating 32-bit throttle pattern. The block asserts ready to the endpoint only when a full block of words is buffered. This lets the host benchmark block-throttled pipe-out transfers and check their integrity against a known sequence.

---
 rtl/bt_pipe_out_source.sv | 136 +++++++++++++
 1 files changed

// File: rtl/bt_pipe_out_source.sv
// Throttled LFSR/counter word source behind a first-word-fall-through FIFO.
// Feeds a block-throttled pipe-out endpoint; ready means one full block is buffered.
module bt_pipe_out_source #(
  parameter int BLOCK_WORDS     = 256,
  parameter int FIFO_DEPTH_LOG2 = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     mode,
  input  logic                     throttle_set,
  input  logic [31:0]              throttle_val,
  input  logic                     pipe_out_read,
  output logic [15:0]              pipe_out_data,
  output logic                     pipe_out_ready,
  output logic [FIFO_DEPTH_LOG2:0] level,
  output logic [15:0]              underflow_count
);

  localparam int AW    = FIFO_DEPTH_LOG2;
  localparam int DEPTH = 1 << AW;

  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW:0]   LVL_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   BLOCK_LVL = (AW+1)'(BLOCK_WORDS);
  localparam logic [15:0]   ONE16     = 16'h0001;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          ready_q, ready_d;
  logic [15:0]   data_q, data_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [15:0]   uf_q, uf_d;
  logic [31:0]   thr_q, thr_d;
  logic [31:0]   lfsr_q, lfsr_d;

  logic [15:0]   ram [DEPTH];

  logic          gen;
  logic          pop;
  logic          full;
  logic          empty;
  logic [15:0]   wdata;
  logic [15:0]   rd_word;
  logic [AW-1:0] rd_next;

  always_comb begin
    full    = level_q[AW];
    empty   = (level_q == '0);
    gen     = thr_q[0] & ~throttle_set & ~full;
    pop     = pipe_out_read & ~empty;
    wdata   = mode ? cnt_q : lfsr_q[15:0];
    rd_next = rd_ptr_q + PTR_ONE;
    rd_word = ram[rd_next];
  end

  always_comb begin
    thr_d    = throttle_set ? throttle_val : {thr_q[0], thr_q[31:1]};
    lfsr_d   = lfsr_q;
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    uf_d     = uf_q;
    data_d   = data_q;

    if (gen) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (mode) begin
        cnt_d = cnt_q + ONE16;
      end else begin
        lfsr_d = {lfsr_q[30:0],
                  lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
      end
    end

    if (pop) begin
      rd_ptr_d = rd_next;
    end

    if (gen && !pop) begin
      level_d = level_q + LVL_ONE;
    end else if (!gen && pop) begin
      level_d = level_q - LVL_ONE;
    end

    if (pipe_out_read && empty && !(&uf_q)) begin
      uf_d = uf_q + ONE16;
    end

    // New word bypasses the RAM when it becomes the head this edge
    if (gen && (empty || (pop && level_q == LVL_ONE))) begin
      data_d = wdata;
    end else if (pop && level_q > LVL_ONE) begin
      data_d = rd_word;
    end

    ready_d = (level_d >= BLOCK_LVL);
  end

  always_ff @(posedge clk) begin
    if (gen) begin
      ram[wr_ptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ready_q  <= 1'b0;
      data_q   <= '0;
      cnt_q    <= 16'h0001;
      uf_q     <= '0;
      thr_q    <= 32'hFFFF_FFFF;
      lfsr_q   <= 32'h0000_0001;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ready_q  <= ready_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
      uf_q     <= uf_d;
      thr_q    <= thr_d;
      lfsr_q   <= lfsr_d;
    end
  end

  assign pipe_out_data   = data_q;
  assign pipe_out_ready  = ready_q;
  assign level           = level_q;
  assign underflow_count = uf_q;

endmodule
